// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: state encodings, parameter limits and width helper for rst_seq_sync
package rst_seq_pkg;
   typedef logic [1:0] state_t;
   localparam state_t ST_ASSERT  = 2'd0;
   localparam state_t ST_HOLD    = 2'd1;
   localparam state_t ST_RELEASE = 2'd2;
   localparam state_t ST_DONE    = 2'd3;
   localparam int MIN_SYNC_STAGES = 2;
   localparam int MIN_PARAM       = 1;
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/rst_seq_sync_if.sv
// rst_seq_sync_if: enable, optional sw request and sequenced reset outputs (RST_SEQ_SW_REQ_EN adds sw_rst_req)
interface rst_seq_sync_if #(parameter int NUM_CH = 4);
   logic              dest_clk_en;
`ifdef RST_SEQ_SW_REQ_EN
   logic              sw_rst_req;
`endif
   logic [NUM_CH-1:0] dest_rst_n;
   logic              rst_busy;
`ifdef RST_SEQ_SW_REQ_EN
   modport master(input dest_clk_en, sw_rst_req, output dest_rst_n, rst_busy);
   modport slave(output dest_clk_en, sw_rst_req, input dest_rst_n, rst_busy);
`else
   modport master(input dest_clk_en, output dest_rst_n, rst_busy);
   modport slave(output dest_clk_en, input dest_rst_n, rst_busy);
`endif
endinterface

// File: rtl/rst_sync_chain.sv
// rst_sync_chain: async-clear, enable-gated shift chain releasing sync_ok after SYNC_STAGES edges
module rst_sync_chain #(parameter int SYNC_STAGES = 2) (
   input  logic dest_clk,
   input  logic src_rst_n,
   input  logic en,
   output logic sync_ok
);
   logic [SYNC_STAGES-1:0] chain;
   always_ff @(posedge dest_clk or negedge src_rst_n)
      if (!src_rst_n) chain <= '0;
      else if (en) chain <= {chain[SYNC_STAGES-2:0], 1'b1};
   assign sync_ok = chain[SYNC_STAGES-1];
endmodule

// File: rtl/rst_seq_sync.sv
// rst_seq_sync: async-assert, sync-release reset sequencer releasing NUM_CH channels in order
// RST_SEQ_SW_REQ_EN enables the synchronous sw_rst_req re-reset input.
module rst_seq_sync
   import rst_seq_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int NUM_CH      = 4,
   parameter int CH_GAP      = 4
) (
   input logic                  dest_clk,
   input logic                  src_rst_n,
   rst_seq_sync_if.master       bus
);
   localparam int CW = clog2((HOLD_CYCLES > CH_GAP ? HOLD_CYCLES : CH_GAP) + 1);
   localparam int IW = clog2(NUM_CH + 1);
   if (SYNC_STAGES < MIN_SYNC_STAGES || HOLD_CYCLES < MIN_PARAM ||
       NUM_CH < MIN_PARAM || CH_GAP < MIN_PARAM) begin : g_param_err
      $error("rst_seq_sync: illegal parameter value");
   end
   state_t            state, state_nx;
   logic [CW-1:0]     cnt, cnt_nx;
   logic [IW-1:0]     ch_idx, ch_nx;
   logic [NUM_CH-1:0] rst_q, rst_nx;
   logic              busy_q, busy_nx;
   logic              sync_ok, sw, hold_end, gap_end, last, step;
`ifdef RST_SEQ_SW_REQ_EN
   assign sw = bus.sw_rst_req;
`else
   assign sw = 1'b0;
`endif
   rst_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .dest_clk (dest_clk),
      .src_rst_n(src_rst_n),
      .en       (bus.dest_clk_en),
      .sync_ok  (sync_ok)
   );
   assign hold_end = cnt == CW'(HOLD_CYCLES - 1);
   assign gap_end  = cnt == CW'(CH_GAP - 1);
   assign last     = ch_idx == IW'(NUM_CH - 1);
   assign step     = (state == ST_HOLD && hold_end) || (state == ST_RELEASE && gap_end);
   always_ff @(posedge dest_clk or negedge src_rst_n)
      if (!src_rst_n) begin
         state  <= ST_ASSERT;
         cnt    <= '0;
         ch_idx <= '0;
         rst_q  <= '0;
         busy_q <= 1'b1;
      end else if (bus.dest_clk_en) begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         ch_idx <= ch_nx;
         rst_q  <= rst_nx;
         busy_q <= busy_nx;
      end
   always_comb
      state_nx = sw                    ? ST_ASSERT :
                 state == ST_ASSERT    ? (sync_ok ? ST_HOLD : ST_ASSERT) :
                 state == ST_HOLD      ? (hold_end ? (NUM_CH == 1 ? ST_DONE : ST_RELEASE) : ST_HOLD) :
                 state == ST_RELEASE   ? (gap_end && last ? ST_DONE : ST_RELEASE) :
                                         ST_DONE;
   // channels release in order, so the output vector fills as a thermometer
   always_comb begin
      cnt_nx  = (sw || step || state == ST_ASSERT || state == ST_DONE) ? '0 : cnt + CW'(1);
      ch_nx   = sw ? '0 : state == ST_HOLD && hold_end ? IW'(1) :
                state == ST_RELEASE && gap_end ? ch_idx + IW'(1) : ch_idx;
      rst_nx  = sw ? '0 : step ? (rst_q << 1) | NUM_CH'(1) : rst_q;
      busy_nx = state_nx != ST_DONE;
   end
   assign bus.dest_rst_n = rst_q;
   assign bus.rst_busy   = busy_q;
endmodule

// File: tb/tb_rst_seq_sync.sv
// tb_rst_seq_sync: scoreboard bench for rst_seq_sync (default DUT plus a minimal-parameter DUT)
// Define RST_SEQ_SW_REQ_EN to also exercise the sw_rst_req path.
module tb_rst_seq_sync;
   typedef struct packed {
      logic [3:0] d;
      logic       b;
      logic       d5;
      logic       b5;
   } exp_t;
   logic dest_clk = 1'b0;
   logic src_rst_n = 1'b0;
   logic en = 1'b1;
   int   n = 0;
   int   off = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   rst_seq_sync_if #(.NUM_CH(4)) bus ();
   rst_seq_sync_if #(.NUM_CH(1)) bus5 ();
   assign bus.dest_clk_en  = en;
   assign bus5.dest_clk_en = en;
`ifdef RST_SEQ_SW_REQ_EN
   logic sw = 1'b0;
   assign bus.sw_rst_req  = sw;
   assign bus5.sw_rst_req = 1'b0;
`endif
   rst_seq_sync dut (.dest_clk(dest_clk), .src_rst_n(src_rst_n), .bus(bus));
   rst_seq_sync #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .NUM_CH(1), .CH_GAP(1)) dut5 (
      .dest_clk(dest_clk), .src_rst_n(src_rst_n), .bus(bus5));
   always #5 dest_clk = ~dest_clk;
   function automatic exp_t model(input int idx, input int e5);
      exp_t e;
      e.d  = idx >= 31 ? 4'b1111 : idx >= 27 ? 4'b0111 : idx >= 23 ? 4'b0011 :
             idx >= 19 ? 4'b0001 : 4'b0000;
      e.b  = idx < 31;
      e.d5 = e5 >= 5;
      e.b5 = e5 < 5;
      return e;
   endfunction
   task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s edge %0d got %b want %b", name, n, act, want);
      end
   endtask
   task automatic check_all(input exp_t e);
      check("dest_rst_n", bus.dest_rst_n, e.d);
      check("rst_busy", {3'b0, bus.rst_busy}, {3'b0, e.b});
      check("dut5_rst_n", {3'b0, bus5.dest_rst_n}, {3'b0, e.d5});
      check("dut5_busy", {3'b0, bus5.rst_busy}, {3'b0, e.b5});
   endtask
   task automatic step(input logic en_v);
      en = en_v;
      if (en_v) n++;
      q.push_back(model(n + off, n));
      @(negedge dest_clk);
   endtask
   task automatic release_rst();
      src_rst_n = 1'b1;
      n = 0;
      off = 0;
   endtask
   initial begin
      exp_t e;
      forever begin
         @(posedge dest_clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check_all(e);
         end
      end
   end
   initial begin
      repeat (5) @(negedge dest_clk);
      check_all(model(0, 0));
      release_rst();
      repeat (35) step(1'b1);
      release_rst();
      src_rst_n = 1'b0;
      #1 check_all(model(0, 0));
      @(negedge dest_clk);
      release_rst();
      repeat (24) step(1'b1);
      src_rst_n = 1'b0;
      #1 check_all(model(0, 0));
      repeat (3) @(negedge dest_clk);
      release_rst();
      repeat (35) step(1'b1);
      src_rst_n = 1'b0;
      #1 check_all(model(0, 0));
      repeat (2) @(negedge dest_clk);
      release_rst();
      repeat (10) step(1'b1);
      repeat (10) step(1'b0);
      repeat (25) step(1'b1);
`ifdef RST_SEQ_SW_REQ_EN
      // pulse edge maps to model index 2 so ch0 lands 17 edges later
      off = 2 - (n + 1);
      sw = 1'b1;
      step(1'b1);
      sw = 1'b0;
      repeat (32) step(1'b1);
`endif
      @(negedge dest_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
